// File: rtl/alu_issue_ctrl.sv
// ID/EX issue stage: decodes RV32I ALU-class (and optionally RV32M) instructions into ALU operands/SELECT.
// Define MEXT_EN to enable M-extension decode and the MWAIT latency hold; otherwise funct7=0000001 is illegal.
module alu_issue_ctrl #(
    parameter int unsigned MUL_LAT = 2,
    parameter int unsigned DIV_LAT = 8
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [31:0] INSTR,
    input  logic [31:0] RS1_DATA,
    input  logic [31:0] RS2_DATA,
    input  logic [31:0] PC,
    input  logic        STALL_IN,
    input  logic        FLUSH,
    output logic        OUT_VALID,
    output logic [31:0] DATA1,
    output logic [31:0] DATA2,
    output logic [4:0]  SELECT,
    output logic [4:0]  RD_ADDR,
    output logic        REG_WRITE,
    output logic        ILLEGAL,
    output logic        BUSY
);
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [4:0] SEL_FWD  = 5'b00000;
    localparam logic [4:0] SEL_ADD  = 5'b00001;
    localparam logic [4:0] SEL_AND  = 5'b00010;
    localparam logic [4:0] SEL_OR   = 5'b00011;
    localparam logic [4:0] SEL_SUB  = 5'b00100;
    localparam logic [4:0] SEL_XOR  = 5'b00101;
    localparam logic [4:0] SEL_SLL  = 5'b00110;
    localparam logic [4:0] SEL_SRL  = 5'b00111;
    localparam logic [4:0] SEL_SRA  = 5'b01000;
    localparam logic [4:0] SEL_SLT  = 5'b01001;
    localparam logic [4:0] SEL_SLTU = 5'b01010;

`ifdef MEXT_EN
    typedef enum logic [1:0] {IDLE, HOLD, MWAIT} state_t;
`else
    typedef enum logic [1:0] {IDLE, HOLD} state_t;
`endif

    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [31:0] imm_i;
    logic [31:0] imm_u;
    logic [31:0] shamt;

    assign opcode = INSTR[6:0];
    assign funct3 = INSTR[14:12];
    assign funct7 = INSTR[31:25];
    assign imm_i  = {{20{INSTR[31]}}, INSTR[31:20]};
    assign imm_u  = {INSTR[31:12], 12'b0};
    assign shamt  = {27'b0, INSTR[24:20]};

    logic [4:0]  dec_sel;
    logic [31:0] dec_d1;
    logic [31:0] dec_d2;
    logic        dec_legal;
`ifdef MEXT_EN
    logic        dec_mop;
`endif

    always_comb begin
        dec_sel   = SEL_FWD;
        dec_d1    = RS1_DATA;
        dec_d2    = RS2_DATA;
        dec_legal = 1'b0;
`ifdef MEXT_EN
        dec_mop   = 1'b0;
`endif
        case (opcode)
            OP_R: begin
                if (funct7 == 7'b0000000) begin
                    dec_legal = 1'b1;
                    case (funct3)
                        3'b000:  dec_sel = SEL_ADD;
                        3'b001:  dec_sel = SEL_SLL;
                        3'b010:  dec_sel = SEL_SLT;
                        3'b011:  dec_sel = SEL_SLTU;
                        3'b100:  dec_sel = SEL_XOR;
                        3'b101:  dec_sel = SEL_SRL;
                        3'b110:  dec_sel = SEL_OR;
                        default: dec_sel = SEL_AND;
                    endcase
                end else if (funct7 == 7'b0100000) begin
                    if (funct3 == 3'b000) begin
                        dec_legal = 1'b1;
                        dec_sel   = SEL_SUB;
                    end else if (funct3 == 3'b101) begin
                        dec_legal = 1'b1;
                        dec_sel   = SEL_SRA;
                    end
                end
`ifdef MEXT_EN
                else if (funct7 == 7'b0000001) begin
                    dec_legal = 1'b1;
                    dec_mop   = 1'b1;
                    dec_sel   = {2'b10, funct3};
                end
`endif
            end
            OP_I: begin
                dec_d2 = imm_i;
                case (funct3)
                    3'b000: begin dec_legal = 1'b1; dec_sel = SEL_ADD;  end
                    3'b010: begin dec_legal = 1'b1; dec_sel = SEL_SLT;  end
                    3'b011: begin dec_legal = 1'b1; dec_sel = SEL_SLTU; end
                    3'b100: begin dec_legal = 1'b1; dec_sel = SEL_XOR;  end
                    3'b110: begin dec_legal = 1'b1; dec_sel = SEL_OR;   end
                    3'b111: begin dec_legal = 1'b1; dec_sel = SEL_AND;  end
                    3'b001: begin
                        dec_d2    = shamt;
                        dec_sel   = SEL_SLL;
                        dec_legal = (funct7 == 7'b0000000);
                    end
                    default: begin
                        dec_d2 = shamt;
                        if (funct7 == 7'b0000000) begin
                            dec_legal = 1'b1;
                            dec_sel   = SEL_SRL;
                        end else if (funct7 == 7'b0100000) begin
                            dec_legal = 1'b1;
                            dec_sel   = SEL_SRA;
                        end
                    end
                endcase
            end
            OP_LUI: begin
                dec_legal = 1'b1;
                dec_sel   = SEL_FWD;
                dec_d1    = '0;
                dec_d2    = imm_u;
            end
            OP_AUIPC: begin
                dec_legal = 1'b1;
                dec_sel   = SEL_ADD;
                dec_d1    = PC;
                dec_d2    = imm_u;
            end
            default: ;
        endcase
        // Illegal words are still issued, but as an inert FWD of zero.
        if (!dec_legal) begin
            dec_sel = SEL_FWD;
            dec_d1  = '0;
            dec_d2  = '0;
`ifdef MEXT_EN
            dec_mop = 1'b0;
`endif
        end
    end

    state_t state, state_n;
    logic   accept;
    logic   load;

`ifdef MEXT_EN
    localparam logic [3:0] MUL_L = 4'(MUL_LAT);
    localparam logic [3:0] DIV_L = 4'(DIV_LAT);
    logic [3:0] cnt, cnt_n;
    logic [3:0] dec_lat;
    assign dec_lat = funct3[2] ? DIV_L : MUL_L;
`else
    logic lat_unused;
    assign lat_unused = (MUL_LAT == 0) || (DIV_LAT == 0);
`endif

    assign IN_READY = RESET_N && !FLUSH && (state == IDLE || (state == HOLD && !STALL_IN));
    assign accept   = IN_VALID && IN_READY;

    always_comb begin
        state_n = state;
        load    = 1'b0;
`ifdef MEXT_EN
        cnt_n   = cnt;
`endif
        case (state)
            IDLE, HOLD: begin
                if (accept) begin
                    load    = 1'b1;
                    state_n = HOLD;
`ifdef MEXT_EN
                    if (dec_mop && dec_lat > 4'd1) begin
                        state_n = MWAIT;
                        cnt_n   = dec_lat - 4'd1;
                    end
`endif
                end else if (state == HOLD && !STALL_IN) begin
                    state_n = IDLE;
                end
            end
`ifdef MEXT_EN
            MWAIT: begin
                if (cnt <= 4'd1) begin
                    state_n = HOLD;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
`endif
            default: state_n = IDLE;
        endcase
        if (FLUSH) begin
            state_n = IDLE;
            load    = 1'b0;
`ifdef MEXT_EN
            cnt_n   = '0;
`endif
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state     <= IDLE;
            DATA1     <= '0;
            DATA2     <= '0;
            SELECT    <= '0;
            RD_ADDR   <= '0;
            REG_WRITE <= 1'b0;
            ILLEGAL   <= 1'b0;
`ifdef MEXT_EN
            cnt       <= '0;
`endif
        end else begin
            state <= state_n;
`ifdef MEXT_EN
            cnt   <= cnt_n;
`endif
            if (load) begin
                DATA1     <= dec_d1;
                DATA2     <= dec_d2;
                SELECT    <= dec_sel;
                RD_ADDR   <= INSTR[11:7];
                REG_WRITE <= dec_legal && (INSTR[11:7] != 5'd0);
                ILLEGAL   <= !dec_legal;
            end
        end
    end

    assign OUT_VALID = (state == HOLD);
`ifdef MEXT_EN
    assign BUSY = (state == MWAIT);
`else
    assign BUSY = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed scenarios plus a randomized run against a
// table-driven decode model and a timestamp-based occupancy model. Honours MEXT_EN like the RTL.
module tb_alu_issue_ctrl;
    localparam int unsigned TB_MUL_LAT = 2;
    localparam int unsigned TB_DIV_LAT = 8;
`ifdef MEXT_EN
    localparam bit MEXT = 1'b1;
`else
    localparam bit MEXT = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [31:0] INSTR = '0;
    logic [31:0] RS1_DATA = '0;
    logic [31:0] RS2_DATA = '0;
    logic [31:0] PC = '0;
    logic        STALL_IN = 1'b0;
    logic        FLUSH = 1'b0;
    logic        OUT_VALID;
    logic [31:0] DATA1;
    logic [31:0] DATA2;
    logic [4:0]  SELECT;
    logic [4:0]  RD_ADDR;
    logic        REG_WRITE;
    logic        ILLEGAL;
    logic        BUSY;

    always #5 CLK = ~CLK;

    alu_issue_ctrl #(.MUL_LAT(TB_MUL_LAT), .DIV_LAT(TB_DIV_LAT)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .INSTR(INSTR), .RS1_DATA(RS1_DATA), .RS2_DATA(RS2_DATA), .PC(PC),
        .STALL_IN(STALL_IN), .FLUSH(FLUSH), .OUT_VALID(OUT_VALID),
        .DATA1(DATA1), .DATA2(DATA2), .SELECT(SELECT), .RD_ADDR(RD_ADDR),
        .REG_WRITE(REG_WRITE), .ILLEGAL(ILLEGAL), .BUSY(BUSY)
    );

    int n_tests = 0;
    int n_fail  = 0;

    localparam int K_R = 0, K_M = 1, K_I = 2, K_SH = 3, K_LUI = 4, K_AUI = 5;

    typedef struct {
        logic [6:0] opc;
        logic [2:0] f3;
        bit         f3_any;
        logic [6:0] f7;
        bit         f7_any;
        logic [4:0] sel;
        int         kind;
    } ent_t;

    typedef struct {
        logic [31:0] d1;
        logic [31:0] d2;
        bit          d1_dc;
        logic [4:0]  sel;
        logic [4:0]  rd;
        logic        rw;
        logic        ill;
        int          lat;
    } exp_t;

    ent_t tab[$];

    task automatic add_ent(input logic [6:0] opc, input logic [2:0] f3, input bit f3a,
                           input logic [6:0] f7, input bit f7a, input logic [4:0] sel, input int kind);
        ent_t e;
        e.opc = opc; e.f3 = f3; e.f3_any = f3a; e.f7 = f7; e.f7_any = f7a; e.sel = sel; e.kind = kind;
        tab.push_back(e);
    endtask

    // Legal instruction list, one row per mnemonic.
    task automatic build_table();
        add_ent(7'b0110011, 3'b000, 0, 7'h00, 0, 5'd1,  K_R);   // ADD
        add_ent(7'b0110011, 3'b001, 0, 7'h00, 0, 5'd6,  K_R);   // SLL
        add_ent(7'b0110011, 3'b010, 0, 7'h00, 0, 5'd9,  K_R);   // SLT
        add_ent(7'b0110011, 3'b011, 0, 7'h00, 0, 5'd10, K_R);   // SLTU
        add_ent(7'b0110011, 3'b100, 0, 7'h00, 0, 5'd5,  K_R);   // XOR
        add_ent(7'b0110011, 3'b101, 0, 7'h00, 0, 5'd7,  K_R);   // SRL
        add_ent(7'b0110011, 3'b110, 0, 7'h00, 0, 5'd3,  K_R);   // OR
        add_ent(7'b0110011, 3'b111, 0, 7'h00, 0, 5'd2,  K_R);   // AND
        add_ent(7'b0110011, 3'b000, 0, 7'h20, 0, 5'd4,  K_R);   // SUB
        add_ent(7'b0110011, 3'b101, 0, 7'h20, 0, 5'd8,  K_R);   // SRA
        for (int f = 0; f < 8; f++)
            add_ent(7'b0110011, 3'(f), 0, 7'h01, 0, 5'(16 + f), K_M);
        add_ent(7'b0010011, 3'b000, 0, 7'h00, 1, 5'd1,  K_I);   // ADDI
        add_ent(7'b0010011, 3'b010, 0, 7'h00, 1, 5'd9,  K_I);   // SLTI
        add_ent(7'b0010011, 3'b011, 0, 7'h00, 1, 5'd10, K_I);   // SLTIU
        add_ent(7'b0010011, 3'b100, 0, 7'h00, 1, 5'd5,  K_I);   // XORI
        add_ent(7'b0010011, 3'b110, 0, 7'h00, 1, 5'd3,  K_I);   // ORI
        add_ent(7'b0010011, 3'b111, 0, 7'h00, 1, 5'd2,  K_I);   // ANDI
        add_ent(7'b0010011, 3'b001, 0, 7'h00, 0, 5'd6,  K_SH);  // SLLI
        add_ent(7'b0010011, 3'b101, 0, 7'h00, 0, 5'd7,  K_SH);  // SRLI
        add_ent(7'b0010011, 3'b101, 0, 7'h20, 0, 5'd8,  K_SH);  // SRAI
        add_ent(7'b0110111, 3'b000, 1, 7'h00, 1, 5'd0,  K_LUI);
        add_ent(7'b0010111, 3'b000, 1, 7'h00, 1, 5'd1,  K_AUI);
    endtask

    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] pc);
        exp_t r;
        r.d1 = '0; r.d2 = '0; r.d1_dc = 0; r.sel = '0; r.rd = ins[11:7];
        r.rw = 1'b0; r.ill = 1'b1; r.lat = 1;
        foreach (tab[i]) begin
            if (tab[i].opc == ins[6:0] && (tab[i].f3_any || tab[i].f3 == ins[14:12]) &&
                (tab[i].f7_any || tab[i].f7 == ins[31:25]) && (tab[i].kind != K_M || MEXT)) begin
                r.ill = 1'b0;
                r.sel = tab[i].sel;
                r.rw  = (ins[11:7] != 5'd0);
                r.d1  = a;
                case (tab[i].kind)
                    K_R:   r.d2 = b;
                    K_M: begin
                        r.d2  = b;
                        r.lat = ins[14] ? int'(TB_DIV_LAT) : int'(TB_MUL_LAT);
                    end
                    K_I:   r.d2 = {{20{ins[31]}}, ins[31:20]};
                    K_SH:  r.d2 = 32'(ins[24:20]);
                    K_LUI: begin r.d2 = {ins[31:12], 12'b0}; r.d1_dc = 1; end
                    default: begin r.d1 = pc; r.d2 = {ins[31:12], 12'b0}; end
                endcase
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] w;
        int k;
        w = $urandom();
        if ($urandom_range(0, 5) == 0) return w;
        k = int'($urandom_range(0, tab.size() - 1));
        w[6:0] = tab[k].opc;
        if (!tab[k].f3_any) w[14:12] = tab[k].f3;
        if (!tab[k].f7_any && $urandom_range(0, 9) != 0) w[31:25] = tab[k].f7;
        if ($urandom_range(0, 3) == 0) w[11:7] = 5'd0;
        return w;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESET_N = 1'b0; IN_VALID = 1'b1; INSTR = 32'h0020_81B3; RS1_DATA = 32'd5; RS2_DATA = 32'd7;
        #1;
        n_tests++;
        if (IN_READY !== 1'b0) begin n_fail++; $display("FAIL reset_ready_low: got %0b want 0", IN_READY); end
        tick();
        tick();
        RESET_N = 1'b1; IN_VALID = 1'b0;
        #1;
        n_tests++;
        if ({OUT_VALID, BUSY, ILLEGAL, REG_WRITE, DATA1, DATA2, SELECT, RD_ADDR} !== 80'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%0b b=%0b il=%0b rw=%0b d1=%h d2=%h sel=%b rd=%0d want all zero",
                     OUT_VALID, BUSY, ILLEGAL, REG_WRITE, DATA1, DATA2, SELECT, RD_ADDR);
        end
        n_tests++;
        if (IN_READY !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after: got %0b want 1", IN_READY); end
    endtask

    task automatic test_back_to_back();
        IN_VALID = 1'b1; INSTR = {7'b0, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
        RS1_DATA = 32'd5; RS2_DATA = 32'd7;
        tick();
        n_tests++;
        if ({OUT_VALID, SELECT, DATA1, DATA2, RD_ADDR, REG_WRITE, ILLEGAL} !== {1'b1, 5'b00001, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_add: got v=%0b sel=%b d1=%h d2=%h rd=%0d rw=%0b il=%0b want v=1 sel=00001 d1=5 d2=7 rd=3 rw=1 il=0",
                     OUT_VALID, SELECT, DATA1, DATA2, RD_ADDR, REG_WRITE, ILLEGAL);
        end
        INSTR = {7'b0100000, 5'd3, 5'd1, 3'b101, 5'd4, 7'b0010011};
        RS1_DATA = 32'hFFFF_FF00;
        #1;
        n_tests++;
        if (IN_READY !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %0b want 1", IN_READY); end
        tick();
        IN_VALID = 1'b0;
        n_tests++;
        if ({OUT_VALID, SELECT, DATA1, DATA2, RD_ADDR} !== {1'b1, 5'b01000, 32'hFFFF_FF00, 32'd3, 5'd4}) begin
            n_fail++;
            $display("FAIL b2b_srai: got v=%0b sel=%b d1=%h d2=%h rd=%0d want v=1 sel=01000 d1=ffffff00 d2=3 rd=4",
                     OUT_VALID, SELECT, DATA1, DATA2, RD_ADDR);
        end
        tick();
        n_tests++;
        if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %0b want 0", OUT_VALID); end
    endtask

    task automatic test_stall();
        IN_VALID = 1'b1; INSTR = {20'h12345, 5'd5, 7'b0110111};
        tick();
        STALL_IN = 1'b1;
        INSTR = {7'b0, 5'd2, 5'd1, 3'b000, 5'd9, 7'b0110011};
        #1;
        n_tests++;
        if (IN_READY !== 1'b0) begin n_fail++; $display("FAIL stall_ready: got %0b want 0", IN_READY); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if ({OUT_VALID, DATA2, SELECT, RD_ADDR, REG_WRITE} !== {1'b1, 32'h1234_5000, 5'b00000, 5'd5, 1'b1}) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got v=%0b d2=%h sel=%b rd=%0d rw=%0b want v=1 d2=12345000 sel=00000 rd=5 rw=1",
                         i, OUT_VALID, DATA2, SELECT, RD_ADDR, REG_WRITE);
            end
        end
        STALL_IN = 1'b0; IN_VALID = 1'b0;
        tick();
        n_tests++;
        if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL stall_release: got %0b want 0", OUT_VALID); end
    endtask

    task automatic test_mext();
        IN_VALID = 1'b1; INSTR = {7'b0000001, 5'd2, 5'd1, 3'b100, 5'd6, 7'b0110011};
        RS1_DATA = 32'd100; RS2_DATA = 32'd7;
        tick();
        IN_VALID = 1'b0;
`ifdef MEXT_EN
        for (int e = 0; e < int'(TB_DIV_LAT) - 1; e++) begin
            n_tests++;
            if ({BUSY, OUT_VALID, IN_READY} !== 3'b100) begin
                n_fail++;
                $display("FAIL div_wait_edge%0d: got busy=%0b v=%0b rdy=%0b want busy=1 v=0 rdy=0", e, BUSY, OUT_VALID, IN_READY);
            end
            tick();
        end
        n_tests++;
        if ({BUSY, OUT_VALID, SELECT, DATA1, DATA2, RD_ADDR} !== {1'b0, 1'b1, 5'b10100, 32'd100, 32'd7, 5'd6}) begin
            n_fail++;
            $display("FAIL div_present: got busy=%0b v=%0b sel=%b d1=%h d2=%h rd=%0d want busy=0 v=1 sel=10100 d1=64 d2=7 rd=6",
                     BUSY, OUT_VALID, SELECT, DATA1, DATA2, RD_ADDR);
        end
`else
        n_tests++;
        if ({BUSY, OUT_VALID, ILLEGAL, REG_WRITE, SELECT} !== {1'b0, 1'b1, 1'b1, 1'b0, 5'b00000}) begin
            n_fail++;
            $display("FAIL div_illegal: got busy=%0b v=%0b il=%0b rw=%0b sel=%b want busy=0 v=1 il=1 rw=0 sel=00000",
                     BUSY, OUT_VALID, ILLEGAL, REG_WRITE, SELECT);
        end
`endif
        tick();
        n_tests++;
        if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL div_drain: got %0b want 0", OUT_VALID); end
    endtask

    task automatic test_flush();
        bit seen_valid;
`ifdef MEXT_EN
        IN_VALID = 1'b1; INSTR = {7'b0000001, 5'd2, 5'd1, 3'b100, 5'd6, 7'b0110011};
        tick();
        IN_VALID = 1'b0;
        tick();
        tick();
        FLUSH = 1'b1;
        #1;
        n_tests++;
        if ({BUSY, IN_READY} !== 2'b10) begin n_fail++; $display("FAIL flush_pre: got busy=%0b rdy=%0b want busy=1 rdy=0", BUSY, IN_READY); end
`else
        IN_VALID = 1'b1; INSTR = {20'hABCDE, 5'd5, 7'b0110111};
        tick();
        IN_VALID = 1'b0; STALL_IN = 1'b1; FLUSH = 1'b1;
        #1;
        n_tests++;
        if ({OUT_VALID, IN_READY} !== 2'b10) begin n_fail++; $display("FAIL flush_pre: got v=%0b rdy=%0b want v=1 rdy=0", OUT_VALID, IN_READY); end
`endif
        tick();
        FLUSH = 1'b0; STALL_IN = 1'b0;
        n_tests++;
        if ({OUT_VALID, BUSY} !== 2'b00) begin n_fail++; $display("FAIL flush_clear: got v=%0b busy=%0b want 0 0", OUT_VALID, BUSY); end
        #1;
        n_tests++;
        if (IN_READY !== 1'b1) begin n_fail++; $display("FAIL flush_idle_ready: got %0b want 1", IN_READY); end
        seen_valid = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (OUT_VALID !== 1'b0 || BUSY !== 1'b0) seen_valid = 1;
        end
        n_tests++;
        if (seen_valid) begin n_fail++; $display("FAIL flush_no_output: got late output=1 want 0"); end
    endtask

    task automatic test_illegal();
        RS1_DATA = 32'hDEAD_BEEF; RS2_DATA = 32'hCAFE_F00D;
        IN_VALID = 1'b1; INSTR = {12'h004, 5'd1, 3'b010, 5'd7, 7'b0000011};
        tick();
        n_tests++;
        if ({OUT_VALID, ILLEGAL, REG_WRITE, SELECT, DATA1, DATA2, BUSY} !== {1'b1, 1'b1, 1'b0, 5'b0, 32'h0, 32'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL illegal_load: got v=%0b il=%0b rw=%0b sel=%b d1=%h d2=%h busy=%0b want v=1 il=1 rw=0 sel=0 d1=0 d2=0 busy=0",
                     OUT_VALID, ILLEGAL, REG_WRITE, SELECT, DATA1, DATA2, BUSY);
        end
        INSTR = {7'b0100000, 5'd3, 5'd1, 3'b001, 5'd8, 7'b0010011};
        tick();
        IN_VALID = 1'b0;
        n_tests++;
        if ({OUT_VALID, ILLEGAL, REG_WRITE, SELECT, DATA1, DATA2, RD_ADDR} !== {1'b1, 1'b1, 1'b0, 5'b0, 32'h0, 32'h0, 5'd8}) begin
            n_fail++;
            $display("FAIL illegal_slli: got v=%0b il=%0b rw=%0b sel=%b d1=%h d2=%h rd=%0d want v=1 il=1 rw=0 sel=0 d1=0 d2=0 rd=8",
                     OUT_VALID, ILLEGAL, REG_WRITE, SELECT, DATA1, DATA2, RD_ADDR);
        end
        tick();
    endtask

    // Occupancy model: one slot, visible once enough edges have passed since acceptance.
    task automatic test_random();
        bit   occ;
        exp_t item;
        exp_t nxt;
        int   vis_at;
        int   cyc;
        bit   exp_vis;
        bit   exp_ready;
        logic [75:0] got;
        logic [75:0] want;
        RESET_N = 1'b0; IN_VALID = 1'b0; STALL_IN = 1'b0; FLUSH = 1'b0;
        tick();
        tick();
        RESET_N = 1'b1;
        occ = 0; vis_at = 0; cyc = 0;
        item = ref_decode(32'h0, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < 1500; i++) begin
            exp_vis = occ && (cyc > vis_at);
            n_tests++;
            if ({OUT_VALID, BUSY} !== {exp_vis, occ && !exp_vis}) begin
                n_fail++;
                $display("FAIL rand_status@%0d: got v=%0b busy=%0b want v=%0b busy=%0b", i, OUT_VALID, BUSY, exp_vis, occ && !exp_vis);
            end
            if (exp_vis) begin
                got  = {item.d1_dc ? 32'h0 : DATA1, DATA2, SELECT, RD_ADDR, REG_WRITE, ILLEGAL};
                want = {item.d1_dc ? 32'h0 : item.d1, item.d2, item.sel, item.rd, item.rw, item.ill};
                n_tests++;
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL rand_fields@%0d: got %h want %h", i, got, want);
                end
            end
            IN_VALID = ($urandom_range(0, 3) != 0);
            INSTR    = gen_instr();
            RS1_DATA = $urandom();
            RS2_DATA = $urandom();
            PC       = $urandom();
            STALL_IN = ($urandom_range(0, 3) == 0);
            FLUSH    = ($urandom_range(0, 39) == 0);
            #1;
            exp_ready = !FLUSH && (!occ || (exp_vis && !STALL_IN));
            n_tests++;
            if (IN_READY !== exp_ready) begin
                n_fail++;
                $display("FAIL rand_ready@%0d: got %0b want %0b", i, IN_READY, exp_ready);
            end
            nxt = ref_decode(INSTR, RS1_DATA, RS2_DATA, PC);
            @(posedge CLK);
            if (FLUSH) begin
                occ = 0;
            end else begin
                if (occ && exp_vis && !STALL_IN) occ = 0;
                if (IN_VALID && exp_ready) begin
                    occ    = 1;
                    item   = nxt;
                    vis_at = cyc + nxt.lat - 1;
                end
            end
            cyc++;
            #1;
        end
        IN_VALID = 1'b0; STALL_IN = 1'b0; FLUSH = 1'b0;
    endtask

    initial begin
        build_table();
        test_reset();
        test_back_to_back();
        test_stall();
        test_mext();
        test_flush();
        test_illegal();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
